dmem_arbiter: RTL

Two-port arbiter and sequencer for the CPU's single-port data memory. It shares the memory between the CPU load/store path (requester C) and the program/data loader port (requester L, used by the bench and the boot loader). It grants one requester at a time with round-robin priority and drives the memory for a fixed, parameterised access latency. It also returns read data with a one-cycle done pulse, and raises a stall to the CPU while a CPU access is outstanding.

---
 rtl/dmem_arbiter_if.sv | 48 ++++
 rtl/dmem_arbiter.sv | 107 ++++++++++
 2 files changed

// File: rtl/dmem_arbiter_if.sv
// Bus bundle between the data-memory arbiter, its two requesters (CPU, loader)
// and the single-port data memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_gnt;
    logic              c_done;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_gnt;
    logic              l_done;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_gnt, c_done, c_rdata,
        output l_gnt, l_done, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    // Requester / memory side
    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_gnt, c_done, c_rdata,
        input  l_gnt, l_done, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and fixed-latency sequencer sharing one single-port data
// memory between the CPU load/store path and the loader port.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  logic            clk,
    input  logic            reset,
    dmem_arbiter_if.slave   bus,
    output logic            stall,
    output logic            busy
);
    localparam int CNT_W = $clog2(MEM_LAT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              last_l;
    logic              win_l;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              c_gnt_q, l_gnt_q;
    logic [DATA_W-1:0] c_rdata_q, l_rdata_q;
    logic              any_req, pick_l, last_cycle, c_done;

    // Loader wins only when alone or when the CPU held the previous grant.
    always_comb begin
        any_req    = bus.c_req | bus.l_req;
        pick_l     = bus.l_req & (~bus.c_req | ~last_l);
        last_cycle = (cnt == CNT_W'(1));
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req)    state_nx = ACCESS;
            ACCESS:  if (last_cycle) state_nx = RESP;
            RESP:                    state_nx = IDLE;
            default:                 state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nx;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            last_l    <= 1'b1;
            win_l     <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            c_gnt_q   <= 1'b0;
            l_gnt_q   <= 1'b0;
            c_rdata_q <= '0;
            l_rdata_q <= '0;
        end else begin
            c_gnt_q <= 1'b0;
            l_gnt_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (any_req) begin
                        win_l     <= pick_l;
                        last_l    <= pick_l;
                        lat_we    <= pick_l ? bus.l_we    : bus.c_we;
                        lat_addr  <= pick_l ? bus.l_addr  : bus.c_addr;
                        lat_wdata <= pick_l ? bus.l_wdata : bus.c_wdata;
                        cnt       <= CNT_W'(MEM_LAT);
                        c_gnt_q   <= ~pick_l;
                        l_gnt_q   <= pick_l;
                    end
                end
                ACCESS: begin
                    cnt <= cnt - CNT_W'(1);
                    if (last_cycle) begin
                        if (win_l) l_rdata_q <= bus.mem_rdata;
                        else       c_rdata_q <= bus.mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    // Command outputs decode the async-reset state so they drop with reset.
    assign bus.mem_en    = (state == ACCESS);
    assign bus.mem_we    = (state == ACCESS) & lat_we;
    assign bus.mem_addr  = lat_addr;
    assign bus.mem_wdata = lat_wdata;

    assign c_done      = (state == RESP) & ~win_l;
    assign bus.c_done  = c_done;
    assign bus.l_done  = (state == RESP) & win_l;
    assign bus.c_gnt   = c_gnt_q;
    assign bus.l_gnt   = l_gnt_q;
    assign bus.c_rdata = c_rdata_q;
    assign bus.l_rdata = l_rdata_q;

    assign stall = bus.c_req & ~c_done;
    assign busy  = (state != IDLE);
endmodule
